// File: rtl/imm_extend_unit.sv
// rtl/imm_extend_unit.sv - immediate extension stage with prefix pairing and output FIFO
module imm_extend_unit #(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  immediate,
  input  logic [2:0]        imm_src,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ext_imm,
  output logic              prefix_pending
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] PREFIXED = 1'b1;

  localparam logic [2:0] MODE_ZERO   = 3'b000;
  localparam logic [2:0] MODE_SIGN   = 3'b001;
  localparam logic [2:0] MODE_UPPER  = 3'b010;
  localparam logic [2:0] MODE_BRANCH = 3'b011;
  localparam logic [2:0] MODE_PREFIX = 3'b100;

  logic [0:0]        state;
  logic [IMM_W-1:0]  prefix_reg;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;

  logic              accept;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] zext;
  logic [DATA_W-1:0] sext;
  logic [DATA_W-1:0] ext_val;
  logic [DATA_W-1:0] push_data;

  assign in_ready       = (count != FULL);
  assign out_valid      = (count != '0);
  assign prefix_pending = (state == PREFIXED);
  assign ext_imm        = out_valid ? mem[rd_ptr] : '0;

  assign accept = in_valid && in_ready;
  assign push   = accept && (imm_src != MODE_PREFIX);
  assign pop    = out_valid && out_ready;

  assign zext = DATA_W'(immediate);
  assign sext = DATA_W'($signed(immediate));

  always_comb begin
    ext_val = zext;
    case (imm_src)
      MODE_ZERO:   ext_val = zext;
      MODE_SIGN:   ext_val = sext;
      MODE_UPPER:  ext_val = zext << IMM_W;
      MODE_BRANCH: ext_val = sext << 2;
      default:     ext_val = zext;
    endcase
  end

  // The second half of a prefix pair ignores its own mode entirely.
  assign push_data = (state == PREFIXED) ? DATA_W'({prefix_reg, immediate}) : ext_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      prefix_reg <= '0;
    end else if (flush) begin
      state      <= IDLE;
      prefix_reg <= '0;
    end else if (accept) begin
      if (imm_src == MODE_PREFIX) begin
        state      <= PREFIXED;
        prefix_reg <= immediate;
      end else begin
        state <= IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_extend_unit.sv
// tb/tb_imm_extend_unit.sv - directed bench with a queue-based reference model for imm_extend_unit
module tb_imm_extend_unit;

  localparam int IMM_W  = 16;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [IMM_W-1:0]  immediate;
  logic [2:0]        imm_src;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] ext_imm;
  logic              prefix_pending;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  logic [DATA_W-1:0] model_q[$];
  bit                model_prefixed;
  logic [IMM_W-1:0]  model_prefix;
  logic [DATA_W-1:0] out_log[$];
  logic [DATA_W-1:0] exp_q[$];

  imm_extend_unit #(.IMM_W(IMM_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .immediate      (immediate),
    .imm_src        (imm_src),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .ext_imm        (ext_imm),
    .prefix_pending (prefix_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Extension rules written as plain integer arithmetic modulo 2**DATA_W.
  function automatic logic [DATA_W-1:0] model_ext(input logic [IMM_W-1:0] imm, input logic [2:0] src);
    longint v, s, r, m;
    m = longint'(1) << DATA_W;
    v = longint'(imm);
    s = (v >= (longint'(1) << (IMM_W - 1))) ? v - (longint'(1) << IMM_W) : v;
    case (src)
      3'd1:    r = s;
      3'd2:    r = v * (longint'(1) << IMM_W);
      3'd3:    r = s * 4;
      default: r = v;
    endcase
    r = ((r % m) + m) % m;
    return DATA_W'(r);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_q.delete();
      model_prefixed = 1'b0;
      model_prefix   = '0;
    end else if (flush) begin
      model_q.delete();
      model_prefixed = 1'b0;
      model_prefix   = '0;
    end else begin
      bit acc;
      acc = in_valid && (model_q.size() != DEPTH);
      if (model_q.size() != 0 && out_ready) void'(model_q.pop_front());
      if (acc) begin
        if (imm_src == 3'b100) begin
          model_prefixed = 1'b1;
          model_prefix   = immediate;
        end else begin
          if (model_prefixed)
            model_q.push_back(longint'(model_prefix) * (longint'(1) << IMM_W) + longint'(immediate));
          else
            model_q.push_back(model_ext(immediate, imm_src));
          model_prefixed = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("out_valid", DATA_W'(out_valid), DATA_W'(model_q.size() != 0));
      check("ext_imm", ext_imm, (model_q.size() != 0) ? model_q[0] : '0);
      check("in_ready", DATA_W'(in_ready), DATA_W'(model_q.size() != DEPTH));
      check("prefix_pending", DATA_W'(prefix_pending), DATA_W'(model_prefixed));
      if (out_valid && out_ready && !flush) out_log.push_back(ext_imm);
    end
  end

  task automatic send(input logic [IMM_W-1:0] imm, input logic [2:0] src);
    bit ok;
    ok = 1'b0;
    in_valid  = 1'b1;
    immediate = imm;
    imm_src   = src;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 100 cycles");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_log(input string name);
    check({name, "_count"}, DATA_W'(out_log.size()), DATA_W'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < out_log.size(); i++)
      check(name, out_log[i], exp_q[i]);
    out_log.delete();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; immediate = '0; imm_src = '0; out_ready = 1'b1;
    #12;
    check("rst_out_valid", DATA_W'(out_valid), 0);
    check("rst_ext_imm", ext_imm, 0);
    check("rst_in_ready", DATA_W'(in_ready), 1);
    check("rst_prefix_pending", DATA_W'(prefix_pending), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;

    send(16'h8001, 3'b000);
    send(16'h8001, 3'b001);
    send(16'h8001, 3'b011);
    idle(4);
    exp_q = '{32'h0000_8001, 32'hFFFF_8001, 32'hFFFE_0004};
    check_log("basic_modes");

    send(16'h1234, 3'b010);
    send(16'hFFFF, 3'b111);
    idle(4);
    exp_q = '{32'h1234_0000, 32'h0000_FFFF};
    check_log("upper_reserved");

    send(16'hDEAD, 3'b100);
    @(negedge clk);
    check("prefix_pend_lit", DATA_W'(prefix_pending), 1);
    check("prefix_nopush_lit", DATA_W'(out_valid), 0);
    @(posedge clk); #1;
    send(16'hBEEF, 3'b001);
    @(negedge clk);
    check("prefix_done_lit", DATA_W'(prefix_pending), 0);
    idle(3);
    exp_q = '{32'hDEAD_BEEF};
    check_log("prefix_pair");

    out_ready = 1'b0;
    fork
      begin
        send(16'h0011, 3'b000);
        send(16'h0022, 3'b000);
        send(16'h0033, 3'b000);
      end
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("full_in_ready_lit", DATA_W'(in_ready), 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    idle(5);
    exp_q = '{32'h11, 32'h22, 32'h33};
    check_log("backpressure");

    fork
      begin
        for (int i = 0; i < 10; i++) send(IMM_W'(i), 3'b000);
      end
      begin
        repeat (30) begin
          @(posedge clk); #1;
          out_ready = ~out_ready;
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    idle(6);
    exp_q.delete();
    for (int i = 0; i < 10; i++) exp_q.push_back(DATA_W'(i));
    check_log("wrap_order");

    out_ready = 1'b0;
    send(16'h0001, 3'b000);
    send(16'hAAAA, 3'b100);
    flush = 1'b1; in_valid = 1'b1; immediate = 16'h7777; imm_src = 3'b000;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid_lit", DATA_W'(out_valid), 0);
    check("flush_prefix_lit", DATA_W'(prefix_pending), 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    out_log.delete();
    send(16'h0005, 3'b000);
    idle(3);
    exp_q = '{32'h0000_0005};
    check_log("after_flush");

    out_ready = 1'b0;
    send(16'h0007, 3'b000);
    send(16'h0009, 3'b100);
    #2;
    check("pre_rst_pending_lit", DATA_W'(prefix_pending), 1);
    rst = 1'b1;
    #1;
    check("arst_out_valid", DATA_W'(out_valid), 0);
    check("arst_ext_imm", ext_imm, 0);
    check("arst_in_ready", DATA_W'(in_ready), 1);
    check("arst_prefix_pending", DATA_W'(prefix_pending), 0);
    @(posedge clk); #2;
    rst = 1'b0;
    out_ready = 1'b1;
    out_log.delete();
    send(16'hFFFC, 3'b011);
    idle(3);
    exp_q = '{32'hFFFF_FFF0};
    check_log("after_reset");

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
